// File: rtl/pulse_pkg.sv
// Shared types and constants for the pulse parameter scheduler.
package pulse_pkg;

    localparam int PER_W         = 8;
    localparam int CP_W          = 8;
    localparam int WID_W_DEF     = 16;
    localparam int PER_SHIFT_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Averaging and step counts of zero behave as one.
    function automatic logic [7:0] at_least_one(input logic [7:0] v);
        return (v == 8'd0) ? 8'd1 : v;
    endfunction

endpackage

// File: rtl/pulse_param_sched_if.sv
// Parameter bus between pulse_control (master) and the scheduler (slave).
interface pulse_param_sched_if #(
    parameter int WID_W = 16
);
    logic                      rxd;
    logic [pulse_pkg::PER_W-1:0] per;
    logic [WID_W-1:0]          p1wid;
    logic [WID_W-1:0]          del;
    logic [WID_W-1:0]          p2wid;
    logic [pulse_pkg::CP_W-1:0]  cp;
    logic                      nut;
    logic [WID_W-1:0]          nut_step;
    logic [7:0]                nut_avg;
    logic [7:0]                nut_n;

    logic [WID_W-1:0]          act_p1wid;
    logic [WID_W-1:0]          act_del;
    logic [WID_W-1:0]          act_p2wid;
    logic [pulse_pkg::CP_W-1:0]  act_cp;
    logic                      cyc_start;
    logic [7:0]                step_idx;
    logic                      pend;
    logic                      sat;

    modport master (
        output rxd, per, p1wid, del, p2wid, cp, nut, nut_step, nut_avg, nut_n,
        input  act_p1wid, act_del, act_p2wid, act_cp, cyc_start, step_idx, pend, sat
    );

    modport slave (
        input  rxd, per, p1wid, del, p2wid, cp, nut, nut_step, nut_avg, nut_n,
        output act_p1wid, act_del, act_p2wid, act_cp, cyc_start, step_idx, pend, sat
    );
endinterface

// File: rtl/period_timer.sv
// Period counter: restarts on load, flags the last clock of a period and
// registers cyc_start for the first clock of each new period.
module period_timer #(
    parameter int CNT_W = 10
) (
    input  logic             clk_pll,
    input  logic             reset,
    input  logic             load_i,
    input  logic             run_i,
    input  logic [CNT_W-1:0] len_i,
    output logic             wrap_o,
    output logic             cyc_start_o
);
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic             cyc_q;

    assign wrap_o      = run_i && (pcnt_q == len_i - CNT_W'(1));
    assign cyc_start_o = cyc_q;

    always_comb begin
        pcnt_d = pcnt_q + CNT_W'(1);
        if (load_i || !run_i || wrap_o) pcnt_d = '0;
    end

    always_ff @(posedge clk_pll or posedge reset) begin
        if (reset) begin
            pcnt_q <= '0;
            cyc_q  <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            cyc_q  <= load_i;
        end
    end
endmodule

// File: rtl/pulse_param_sched.sv
// Stages parameter sets from rxd, commits them only at period boundaries,
// drives the period timebase and steps pulse-1 width for nutation sweeps.
module pulse_param_sched
    import pulse_pkg::*;
#(
    parameter int PER_SHIFT = PER_SHIFT_DEF,
    parameter int WID_W     = WID_W_DEF
) (
    input  logic               clk_pll,
    input  logic               reset,
    pulse_param_sched_if.slave bus
);
    localparam int CNT_W = PER_W + PER_SHIFT;

    state_t            state_q, state_d;
    logic              pend_q;
    logic              commit, load, wrap;
    logic [CNT_W-1:0]  len;

    logic [PER_W-1:0]  stg_per_q, act_per_q;
    logic [WID_W-1:0]  stg_p1_q, stg_del_q, stg_p2_q, stg_step_q;
    logic [CP_W-1:0]   stg_cp_q, act_cp_q;
    logic              stg_nut_q, act_nut_q;
    logic [7:0]        stg_avg_q, stg_n_q, act_avg_q, act_n_q;
    logic [WID_W-1:0]  act_base_q, act_del_q, act_p2_q, act_step_q;

    logic [WID_W-1:0]  acc_q, acc_d;
    logic              sat_q, sat_d;
    logic [7:0]        idx_q, idx_d, avg_q, avg_d;
    logic [WID_W:0]    sum;

    assign len = CNT_W'(act_per_q) << PER_SHIFT;

    period_timer #(.CNT_W(CNT_W)) u_timer (
        .clk_pll     (clk_pll),
        .reset       (reset),
        .load_i      (load),
        .run_i       (state_q == RUN),
        .len_i       (len),
        .wrap_o      (wrap),
        .cyc_start_o (bus.cyc_start)
    );

    // A staged per of zero is still committed but leaves the timebase stopped.
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: if (pend_q) begin
                commit = 1'b1;
                if (stg_per_q != '0) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: if (wrap) begin
                commit = pend_q;
                if (pend_q && stg_per_q == '0) state_d = IDLE;
                else                           load    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        idx_d = idx_q;
        avg_d = avg_q;
        sum   = {1'b0, acc_q} + {1'b0, act_step_q};
        if (commit) begin
            acc_d = stg_p1_q;
            sat_d = 1'b0;
            idx_d = '0;
            avg_d = '0;
        end else if (wrap && act_nut_q) begin
            avg_d = avg_q + 8'd1;
            if (avg_q == at_least_one(act_avg_q) - 8'd1) begin
                avg_d = '0;
                if (idx_q == at_least_one(act_n_q) - 8'd1) begin
                    idx_d = '0;
                    acc_d = act_base_q;
                    sat_d = 1'b0;
                end else begin
                    idx_d = idx_q + 8'd1;
                    acc_d = sum[WID_W] ? '1 : sum[WID_W-1:0];
                    sat_d = sum[WID_W];
                end
            end
        end
    end

    always_ff @(posedge clk_pll or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            stg_per_q  <= '0;
            stg_p1_q   <= '0;
            stg_del_q  <= '0;
            stg_p2_q   <= '0;
            stg_cp_q   <= '0;
            stg_nut_q  <= 1'b0;
            stg_step_q <= '0;
            stg_avg_q  <= '0;
            stg_n_q    <= '0;
            act_per_q  <= '0;
            act_base_q <= '0;
            act_del_q  <= '0;
            act_p2_q   <= '0;
            act_cp_q   <= '0;
            act_nut_q  <= 1'b0;
            act_step_q <= '0;
            act_avg_q  <= '0;
            act_n_q    <= '0;
            acc_q      <= '0;
            sat_q      <= 1'b0;
            idx_q      <= '0;
            avg_q      <= '0;
        end else begin
            state_q <= state_d;
            // A strobe on the commit edge re-arms pend with the newer set.
            pend_q  <= bus.rxd | (pend_q & ~commit);
            if (bus.rxd) begin
                stg_per_q  <= bus.per;
                stg_p1_q   <= bus.p1wid;
                stg_del_q  <= bus.del;
                stg_p2_q   <= bus.p2wid;
                stg_cp_q   <= bus.cp;
                stg_nut_q  <= bus.nut;
                stg_step_q <= bus.nut_step;
                stg_avg_q  <= bus.nut_avg;
                stg_n_q    <= bus.nut_n;
            end
            if (commit) begin
                act_per_q  <= stg_per_q;
                act_base_q <= stg_p1_q;
                act_del_q  <= stg_del_q;
                act_p2_q   <= stg_p2_q;
                act_cp_q   <= stg_cp_q;
                act_nut_q  <= stg_nut_q;
                act_step_q <= stg_step_q;
                act_avg_q  <= stg_avg_q;
                act_n_q    <= stg_n_q;
            end
            acc_q <= acc_d;
            sat_q <= sat_d;
            idx_q <= idx_d;
            avg_q <= avg_d;
        end
    end

    assign bus.act_p1wid = acc_q;
    assign bus.act_del   = act_del_q;
    assign bus.act_p2wid = act_p2_q;
    assign bus.act_cp    = act_cp_q;
    assign bus.step_idx  = idx_q;
    assign bus.pend      = pend_q;
    assign bus.sat       = sat_q;
endmodule

// File: tb/tb_pulse_param_sched.sv
// Scoreboard bench for pulse_param_sched with PER_SHIFT=2 (period of 12 clocks for per=3).
module tb_pulse_param_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc_n = 0;
    int   last_cyc = 0;
    logic [15:0] last_p1 = '0;

    typedef struct {
        int          gap;
        int          pre;
        logic [15:0] p1;
        logic [7:0]  idx;
        logic        sat;
        logic [15:0] dl;
        logic [15:0] p2;
        logic [7:0]  cp;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    pulse_param_sched_if #(.WID_W(16)) bus ();

    pulse_param_sched #(.PER_SHIFT(2), .WID_W(16)) dut (
        .clk_pll (clk),
        .reset   (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int gap, input int pre, input logic [15:0] p1,
                        input logic [7:0] idx, input logic sat,
                        input logic [15:0] dl, input logic [15:0] p2, input logic [7:0] cp);
        exp_t e;
        e.gap = gap; e.pre = pre; e.p1 = p1; e.idx = idx; e.sat = sat;
        e.dl = dl; e.p2 = p2; e.cp = cp;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; returns on the following negedge with rxd low again.
    task automatic send(input logic [7:0] per, input logic [15:0] p1, input logic [15:0] dl,
                        input logic [15:0] p2, input logic [7:0] cp, input logic nut,
                        input logic [15:0] st, input logic [7:0] av, input logic [7:0] nn);
        bus.per = per; bus.p1wid = p1; bus.del = dl; bus.p2wid = p2; bus.cp = cp;
        bus.nut = nut; bus.nut_step = st; bus.nut_avg = av; bus.nut_n = nn;
        bus.rxd = 1'b1;
        @(negedge clk);
        bus.rxd = 1'b0;
    endtask

    task automatic wait_cyc(input int k);
        int seen = 0;
        int t = 0;
        while (seen < k && t < 300) begin
            @(negedge clk);
            t++;
            if (bus.cyc_start) seen++;
        end
        if (seen < k) chk("cyc_timeout", seen, k);
    endtask

    task automatic count_cyc(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.cyc_start) cnt++;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.cyc_start) begin
            if (exp_q.size() == 0) begin
                chk("cyc_unexpected", 1, 0);
            end else begin
                cur = exp_q.pop_front();
                if (cur.gap >= 0) chk("cyc_gap", cyc_n - last_cyc, cur.gap);
                if (cur.pre >= 0) chk("p1_before_wrap", 32'(last_p1), cur.pre);
                chk("act_p1wid", 32'(bus.act_p1wid), 32'(cur.p1));
                chk("step_idx", 32'(bus.step_idx), 32'(cur.idx));
                chk("sat", 32'(bus.sat), 32'(cur.sat));
                chk("act_del", 32'(bus.act_del), 32'(cur.dl));
                chk("act_p2wid", 32'(bus.act_p2wid), 32'(cur.p2));
                chk("act_cp", 32'(bus.act_cp), 32'(cur.cp));
            end
            last_cyc = cyc_n;
        end
        last_p1 = bus.act_p1wid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bus.rxd = 1'b0; bus.per = '0; bus.p1wid = '0; bus.del = '0; bus.p2wid = '0;
        bus.cp = '0; bus.nut = 1'b0; bus.nut_step = '0; bus.nut_avg = '0; bus.nut_n = '0;
        tick(2);
        chk("rst_p1", 32'(bus.act_p1wid), 0);
        chk("rst_pend", 32'(bus.pend), 0);
        chk("rst_cyc", 32'(bus.cyc_start), 0);
        chk("rst_idx", 32'(bus.step_idx), 0);
        rst = 1'b0;
        tick(2);

        // Basic commit from IDLE and 12-clock period spacing
        push(-1, -1, 16'd10, 8'd0, 1'b0, 16'd20, 16'd30, 8'd4);
        repeat (3) push(12, 10, 16'd10, 8'd0, 1'b0, 16'd20, 16'd30, 8'd4);
        send(8'd3, 16'd10, 16'd20, 16'd30, 8'd4, 1'b0, 16'd0, 8'd0, 8'd0);
        chk("basic_pend", 32'(bus.pend), 1);
        chk("basic_early", 32'(bus.act_p1wid), 0);
        tick(1);
        chk("basic_cyc", 32'(bus.cyc_start), 1);
        chk("basic_p1", 32'(bus.act_p1wid), 10);
        chk("basic_pend_clr", 32'(bus.pend), 0);
        wait_cyc(3);

        // Mid-period update commits only at the wrap
        push(12, 10, 16'd50, 8'd0, 1'b0, 16'd20, 16'd30, 8'd4);
        push(12, 50, 16'd50, 8'd0, 1'b0, 16'd20, 16'd30, 8'd4);
        tick(5);
        send(8'd3, 16'd50, 16'd20, 16'd30, 8'd4, 1'b0, 16'd0, 8'd0, 8'd0);
        chk("bnd_pend", 32'(bus.pend), 1);
        chk("bnd_hold", 32'(bus.act_p1wid), 10);
        wait_cyc(1);
        chk("bnd_pend_clr", 32'(bus.pend), 0);
        wait_cyc(1);

        // rxd on the commit edge: older set commits, newer stays pending
        push(12, 50, 16'd60, 8'd0, 1'b0, 16'd20, 16'd30, 8'd4);
        push(12, 60, 16'd70, 8'd0, 1'b0, 16'd20, 16'd30, 8'd4);
        tick(3);
        send(8'd3, 16'd60, 16'd20, 16'd30, 8'd4, 1'b0, 16'd0, 8'd0, 8'd0);
        tick(7);
        send(8'd3, 16'd70, 16'd20, 16'd30, 8'd4, 1'b0, 16'd0, 8'd0, 8'd0);
        chk("col_cyc", 32'(bus.cyc_start), 1);
        chk("col_pend", 32'(bus.pend), 1);
        chk("col_p1", 32'(bus.act_p1wid), 60);
        wait_cyc(1);
        chk("col_pend_clr", 32'(bus.pend), 0);

        // Nutation sweep: base 100, step 5, avg 2, 3 steps
        push(12, 70, 16'd100, 8'd0, 1'b0, 16'd20, 16'd30, 8'd4);
        push(12, 100, 16'd100, 8'd0, 1'b0, 16'd20, 16'd30, 8'd4);
        push(12, 100, 16'd105, 8'd1, 1'b0, 16'd20, 16'd30, 8'd4);
        push(12, 105, 16'd105, 8'd1, 1'b0, 16'd20, 16'd30, 8'd4);
        push(12, 105, 16'd110, 8'd2, 1'b0, 16'd20, 16'd30, 8'd4);
        push(12, 110, 16'd110, 8'd2, 1'b0, 16'd20, 16'd30, 8'd4);
        push(12, 110, 16'd100, 8'd0, 1'b0, 16'd20, 16'd30, 8'd4);
        tick(2);
        send(8'd3, 16'd100, 16'd20, 16'd30, 8'd4, 1'b1, 16'd5, 8'd2, 8'd3);
        wait_cyc(7);

        // Saturation: 0xFFF0 + 0x20 overflows
        push(12, 100, 16'hFFF0, 8'd0, 1'b0, 16'd20, 16'd30, 8'd4);
        push(12, 16'hFFF0, 16'hFFFF, 8'd1, 1'b1, 16'd20, 16'd30, 8'd4);
        push(12, 16'hFFFF, 16'hFFF0, 8'd0, 1'b0, 16'd20, 16'd30, 8'd4);
        tick(2);
        send(8'd3, 16'hFFF0, 16'd20, 16'd30, 8'd4, 1'b1, 16'h0020, 8'd1, 8'd2);
        wait_cyc(3);

        // per=0: current period runs to completion, then the timebase stops
        tick(2);
        send(8'd0, 16'd7, 16'h33, 16'h44, 8'd9, 1'b0, 16'd0, 8'd0, 8'd0);
        chk("stop_pend", 32'(bus.pend), 1);
        tick(8);
        chk("stop_no_trunc", 32'(bus.act_p1wid), 32'hFFF0);
        tick(1);
        chk("stop_cyc", 32'(bus.cyc_start), 0);
        chk("stop_pend_clr", 32'(bus.pend), 0);
        chk("stop_p1", 32'(bus.act_p1wid), 7);
        chk("stop_del", 32'(bus.act_del), 32'h33);
        count_cyc(30, cnt);
        chk("stop_quiet", cnt, 0);

        // Re-arm from IDLE, then async reset mid-period
        push(-1, 7, 16'd10, 8'd0, 1'b0, 16'd20, 16'd30, 8'd4);
        send(8'd3, 16'd10, 16'd20, 16'd30, 8'd4, 1'b0, 16'd0, 8'd0, 8'd0);
        tick(1);
        chk("rearm_cyc", 32'(bus.cyc_start), 1);
        tick(2);
        send(8'd3, 16'd99, 16'd20, 16'd30, 8'd4, 1'b0, 16'd0, 8'd0, 8'd0);
        chk("rst_pre_pend", 32'(bus.pend), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_p1", 32'(bus.act_p1wid), 0);
        chk("arst_del", 32'(bus.act_del), 0);
        chk("arst_pend", 32'(bus.pend), 0);
        chk("arst_cyc", 32'(bus.cyc_start), 0);
        tick(3);
        rst = 1'b0;
        count_cyc(30, cnt);
        chk("arst_quiet", cnt, 0);
        chk("sb_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pulse_param_sched.md
Name: pulse_param_sched

Overview:
- Scheduler/configurator between pulse_control and the pulses datapath, in the clk_pll domain.
- Holds the active pulse parameter set and accepts new sets from the rx_done strobe.
- Commits a new set only at a period boundary, so the datapath never sees a mid-period change.
- Generates the period timebase (cyc_start) and steps the pulse-1 width for nutation sweeps.

Parameters:
- PER_SHIFT, 8: period unit is 2^PER_SHIFT clk_pll cycles.
- WID_W, 16: width of the p1wid, del, p2wid and nut_step fields.

Ports:
- clk_pll  in  1  201 MHz PLL clock
- reset  in  1  async, active-high
- rxd  in  1  one-cycle strobe: staged inputs valid (already synchronised to clk_pll upstream)
- per  in  8  period in units of 2^PER_SHIFT clocks; 0 = stop
- p1wid  in  WID_W  pulse-1 base width
- del  in  WID_W  pulse-1 to pulse-2 delay
- p2wid  in  WID_W  pulse-2 width
- cp  in  8  CPMG count
- nut  in  1  nutation sweep enable
- nut_step  in  WID_W  p1 width increment per step
- nut_avg  in  8  periods per step (0 treated as 1)
- nut_n  in  8  steps per sweep before wrap (0 treated as 1)
- act_p1wid  out  WID_W  active p1 width to pulses
- act_del  out  WID_W  active delay
- act_p2wid  out  WID_W  active p2 width
- act_cp  out  8  active CPMG count
- cyc_start  out  1  one-cycle strobe, first clock of each period
- step_idx  out  8  current sweep step
- pend  out  1  staged set waiting for commit
- sat  out  1  swept width saturated this step

Behaviour:
- Reset (async):
  - All outputs, staging regs, counters and pend go to 0; state IDLE.
  - Reset mid-period aborts immediately; no further cyc_start until re-armed.
- Staging:
  - On a rxd edge, all inputs are captured into staging regs and pend<=1, in any state.
  - A later rxd before commit overwrites the staged set (last wins).
- Period length: L = per << PER_SHIFT clocks; counter pcnt runs 0..L-1 (width 8+PER_SHIFT).
- States:
  - IDLE: cyc_start=0.
    - If pend and staged per!=0: at the next edge commit (active<=staged, pend<=0, pcnt<=0, step_idx<=0, avg cnt<=0) and go to RUN.
    - If staged per==0: commit the values, stay IDLE.
    - Commit latency from rxd: 2 edges; first cyc_start is in the cycle after commit.
  - RUN: cyc_start registered high while pcnt==0.
    - At pcnt==L-1 with pend: commit as in IDLE. New values first apply with the next cyc_start; the boundary timing is unchanged.
    - Committed per==0: go to IDLE after the current period ends (no truncation).
- Simultaneous rxd and commit edge: the commit uses the previously staged set; the new set is captured and pend stays 1.
- Sweep:
  - Active only when the committed nut=1; otherwise act_p1wid=base and step_idx=0.
  - At each period wrap the avg counter increments. Reaching max(nut_avg,1) clears it and advances step_idx.
  - step_idx wraps to 0 after max(nut_n,1)-1.
  - Width is accumulated, not multiplied: acc<=acc+nut_step, computed as a WID_W+1 sum.
    - Overflow gives act_p1wid=all ones and sat=1 for that step.
    - On step wrap, acc<=base and sat<=0.
  - act_p1wid changes only on the same edge as the period wrap.
- act_del, act_p2wid and act_cp are constant between commits.

Decomposition:
- Shared package pulse_pkg:
  - PER_W=8, CP_W=8, WID_W default.
  - State enum {IDLE, RUN}.
  - Period-unit constant PER_SHIFT default.
- Sub-module period_timer:
  - Period counter, wrap detect and registered cyc_start.
  - Inputs: load, len, run.
- Staging, commit FSM and sweep accumulator stay in pulse_param_sched.

Test Plan:
- Basic: PER_SHIFT=2, per=3, p1wid=10, del=20, p2wid=30, rxd at t0 -> act_* update at t0+2; cyc_start every 12 clocks, first in cycle t0+2.
- Boundary commit: in RUN, rxd with p1wid=50 mid-period -> pend=1; act_p1wid changes exactly on the wrap edge; period spacing stays 12; pend=0 after.
- Collision: rxd coincident with the commit edge -> the older set is committed, the newer set stays pending and commits at the next boundary.
- Sweep: nut=1, base 100, step 5, nut_avg=2, nut_n=3 -> act_p1wid follows 100,100,105,105,110,110,100...; step_idx follows 0,0,1,1,2,2,0.
- Saturation: base 0xFFF0, step 0x20 -> step 1 gives act_p1wid=0xFFFF, sat=1; wrap restores 0xFFF0, sat=0.
- Stop/reset: commit per=0 -> current period completes, then no cyc_start. Async reset mid-period -> outputs 0 immediately, pend=0.
